uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx_arbiter_rr_pick.sv | 36 +++
 rtl/uart_tx_arbiter.sv | 114 +++++++++++
 tb/tb_uart_tx_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit path: arbiter FSM states,
// the default requester count and counter sizing.
package uart_pkg;

    localparam int DEFAULT_NUM_REQ = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SEND
    } arb_state_t;

    // A counter must be at least one bit wide, even for a one-cycle timeout.
    function automatic int cnt_width(input int cycles);
        return (cycles > 1) ? $clog2(cycles) : 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: the first active request found searching
// upward from (ptr + 1), wrapping from NUM_REQ-1 back to 0.
module rr_pick
    import uart_pkg::*;
#(
    parameter int NUM_REQ = DEFAULT_NUM_REQ
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] ptr,
    output logic [NUM_REQ-1:0]         grant,
    output logic [$clog2(NUM_REQ)-1:0] idx,
    output logic                       any
);

    localparam int IDX_W = $clog2(NUM_REQ);

    int j;

    // NOTE: every output gets a default before the loop, so no path leaves
    // a value unassigned and no latch is inferred.
    always_comb begin
        grant = '0;
        idx   = '0;
        any   = 1'b0;
        j     = 0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            j = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[j]) begin
                any      = 1'b1;
                idx      = IDX_W'(j);
                grant[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte sources. An owner is locked
// for a whole message and loses the grant only on its LAST byte or on idle timeout.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int TIMEOUT_CYCLES = 50_000
) (
    input  logic                    ACLK,
    input  logic                    RESET,
    input  logic [NUM_REQ-1:0]      REQ_VALID,
    input  logic [NUM_REQ-1:0][7:0] REQ_DATA,
    input  logic [NUM_REQ-1:0]      REQ_LAST,
    output logic [NUM_REQ-1:0]      REQ_READY,
    output logic [7:0]              TX_DATA,
    output logic                    TX_DATA_VALID,
    input  logic                    TX_DATA_READ,
    output logic [NUM_REQ-1:0]      GRANT,
    output logic                    TIMEOUT_PULSE
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t         state;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   rr_ptr;
    logic [CNT_W-1:0]   idle_cnt;
    logic               tx_last;

    logic [NUM_REQ-1:0] pick_grant;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req   (REQ_VALID),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx),
        .any   (pick_any)
    );

    // NOTE: all state updates use non-blocking assignments so every register
    // samples pre-edge values and simulation matches the synthesized flops.
    always_ff @(posedge ACLK or posedge RESET) begin
        if (RESET) begin
            state         <= IDLE;
            owner         <= '0;
            rr_ptr        <= IDX_W'(NUM_REQ - 1);
            idle_cnt      <= '0;
            tx_last       <= 1'b0;
            GRANT         <= '0;
            REQ_READY     <= '0;
            TX_DATA       <= 8'h00;
            TX_DATA_VALID <= 1'b0;
            TIMEOUT_PULSE <= 1'b0;
        end else begin
            TIMEOUT_PULSE <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_any) begin
                        owner     <= pick_idx;
                        GRANT     <= pick_grant;
                        REQ_READY <= pick_grant;
                        idle_cnt  <= '0;
                        state     <= LOAD;
                    end
                end

                LOAD: begin
                    // READY is high for the owner throughout LOAD, so its VALID is the handshake.
                    if (REQ_VALID[owner]) begin
                        TX_DATA       <= REQ_DATA[owner];
                        tx_last       <= REQ_LAST[owner];
                        TX_DATA_VALID <= 1'b1;
                        REQ_READY     <= '0;
                        idle_cnt      <= '0;
                        state         <= SEND;
                    end else if (idle_cnt == CNT_MAX) begin
                        TIMEOUT_PULSE <= 1'b1;
                        GRANT         <= '0;
                        REQ_READY     <= '0;
                        rr_ptr        <= owner;
                        idle_cnt      <= '0;
                        state         <= IDLE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end

                SEND: begin
                    if (TX_DATA_READ) begin
                        TX_DATA_VALID <= 1'b0;
                        if (tx_last) begin
                            GRANT  <= '0;
                            rr_ptr <= owner;
                            state  <= IDLE;
                        end else begin
                            REQ_READY <= GRANT;
                            idle_cnt  <= '0;
                            state     <= LOAD;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: directed scenarios plus randomized
// message traffic scored against a message-level round-robin model.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int TO = 16;

    typedef struct {
        int         owner;
        logic [7:0] data;
    } tx_item_t;

    logic              aclk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid;
    logic [N-1:0][7:0] req_data;
    logic [N-1:0]      req_last;
    logic [N-1:0]      req_ready;
    logic [7:0]        tx_data;
    logic              tx_data_valid;
    logic              tx_read;
    logic [N-1:0]      grant;
    logic              timeout_pulse;

    always #5 aclk = ~aclk;

    uart_tx_arbiter #(
        .NUM_REQ        (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .ACLK          (aclk),
        .RESET         (reset),
        .REQ_VALID     (req_valid),
        .REQ_DATA      (req_data),
        .REQ_LAST      (req_last),
        .REQ_READY     (req_ready),
        .TX_DATA       (tx_data),
        .TX_DATA_VALID (tx_data_valid),
        .TX_DATA_READ  (tx_read),
        .GRANT         (grant),
        .TIMEOUT_PULSE (timeout_pulse)
    );

    int errors = 0;
    int checks = 0;

    logic [8:0] q  [N][$];   // bytes each requester still has to offer {last, data}
    logic [8:0] mq [N][$];   // same bytes, not yet consumed by the model
    tx_item_t   exp_q[$];    // expected transmitter stream
    int         mptr;

    logic [N-1:0] rdy_seen, gnt_seen;
    logic         txv_seen, tm_seen;
    logic [7:0]   txd_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_byte(input int i, input logic [7:0] d, input logic last);
        q[i].push_back({last, d});
        mq[i].push_back({last, d});
    endtask

    // Whole-message round robin: next pending requester after the last owner
    // sends its bytes up to LAST (or until it runs dry, which means a timeout).
    task automatic build_expected();
        int         owner;
        bit         found;
        logic [8:0] b;
        forever begin
            found = 0;
            owner = 0;
            for (int k = 1; k <= N; k++) begin
                if (!found && mq[(mptr + k) % N].size() > 0) begin
                    found = 1;
                    owner = (mptr + k) % N;
                end
            end
            if (!found) break;
            do begin
                b = mq[owner].pop_front();
                exp_q.push_back('{owner, b[7:0]});
            end while (!b[8] && mq[owner].size() > 0);
            mptr = owner;
        end
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            if (q[i].size() > 0) begin
                req_valid[i] = 1'b1;
                req_data[i]  = q[i][0][7:0];
                req_last[i]  = q[i][0][8];
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = 8'h00;
                req_last[i]  = 1'b0;
            end
        end
    endtask

    // One clock: retire handshakes of the last edge, sample outputs, drive inputs.
    // rd_mode: 0 never read, 1 random read, 2 read whenever a byte is offered.
    task automatic step(input int rd_mode);
        logic [8:0] b;
        tx_item_t   it;
        bit         rd;
        @(negedge aclk);
        for (int i = 0; i < N; i++)
            if (req_valid[i] && rdy_seen[i]) b = q[i].pop_front();
        rdy_seen = req_ready;
        gnt_seen = grant;
        txv_seen = tx_data_valid;
        txd_seen = tx_data;
        tm_seen  = timeout_pulse;
        drive();
        rd = txv_seen && (rd_mode == 2 || (rd_mode == 1 && $urandom_range(0, 2) != 0));
        if (rd) begin
            if (exp_q.size() == 0) begin
                check("unexpected_tx", 32'd1, 32'd0);
            end else begin
                it = exp_q.pop_front();
                check("tx_data", 32'(txd_seen), 32'(it.data));
                check("tx_grant", 32'(gnt_seen), 32'(1) << it.owner);
            end
        end
        tx_read = rd;
    endtask

    task automatic run_all(input int max_cycles);
        int n = 0;
        while (exp_q.size() > 0 && n < max_cycles) begin
            step(1);
            n++;
        end
        check("run_complete", 32'(exp_q.size()), 32'd0);
        step(0);
        step(0);
        check("grant_released", 32'(gnt_seen), 32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_read   = 1'b0;
        for (int i = 0; i < N; i++) begin
            q[i].delete();
            mq[i].delete();
        end
        exp_q.delete();
        mptr     = N - 1;
        rdy_seen = '0;
        gnt_seen = '0;
        txv_seen = 1'b0;
        txd_seen = 8'h00;
        tm_seen  = 1'b0;
        repeat (2) @(negedge aclk);
        reset = 1'b0;
    endtask

    initial begin
        int         n, load_cycles, bad_stable, bad_tm, bad_rdy;
        logic [7:0] held;

        // Reset values
        do_reset();
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        check("rst_txv", 32'(tx_data_valid), 32'd0);
        check("rst_txd", 32'(tx_data), 32'd0);
        check("rst_timeout", 32'(timeout_pulse), 32'd0);

        // A read pulse while idle is ignored
        step(0);
        tx_read = 1'b1;
        step(0);
        check("idle_read_txv", 32'(txv_seen), 32'd0);
        check("idle_read_grant", 32'(gnt_seen), 32'd0);

        // Single requester, three-byte message, plus latency
        push_byte(0, 8'h41, 1'b0);
        push_byte(0, 8'h42, 1'b0);
        push_byte(0, 8'h43, 1'b1);
        build_expected();
        step(0);
        check("lat_grant_before", 32'(gnt_seen), 32'd0);
        step(0);
        check("lat_grant", 32'(gnt_seen), 32'b0001);
        step(0);
        check("lat_txv", 32'(txv_seen), 32'd1);
        check("lat_txd", 32'(txd_seen), 32'h41);
        run_all(200);

        // All four requesters, requester 0 twice: wrap-around order
        do_reset();
        push_byte(0, 8'hA0, 1'b1);
        push_byte(1, 8'hA1, 1'b1);
        push_byte(2, 8'hA2, 1'b1);
        push_byte(3, 8'hA3, 1'b1);
        push_byte(0, 8'hA4, 1'b1);
        build_expected();
        run_all(300);

        // Lock held: requester 1 waits for owner 2's LAST byte
        do_reset();
        push_byte(2, 8'hC0, 1'b0);
        push_byte(2, 8'hC1, 1'b0);
        push_byte(2, 8'hC2, 1'b1);
        build_expected();
        n = 0;
        while (!(gnt_seen == 4'b0100 && q[2].size() < 3) && n < 50) begin
            step(1);
            n++;
        end
        check("lock_owner2_started", 32'(gnt_seen), 32'b0100);
        push_byte(1, 8'hB0, 1'b0);
        push_byte(1, 8'hB1, 1'b1);
        build_expected();
        n = 0;
        while (gnt_seen == 4'b0100 && n < 200) begin
            step(1);
            check("lock_no_ready_r1", 32'(rdy_seen[1]), 32'd0);
            n++;
        end
        run_all(300);

        // Owner 0 goes silent mid-message: timeout, then pending requester 3
        do_reset();
        push_byte(3, 8'h77, 1'b1);
        push_byte(0, 8'h55, 1'b0);
        build_expected();
        n = 0;
        while (exp_q.size() > 1 && n < 50) begin
            step(2);
            n++;
        end
        load_cycles = 0;
        n = 0;
        do begin
            step(0);
            if (!tm_seen && rdy_seen[0]) load_cycles++;
            n++;
        end while (!tm_seen && n < 100);
        check("timeout_pulse", 32'(tm_seen), 32'd1);
        check("timeout_load_cycles", 32'(load_cycles), 32'd16);
        check("timeout_grant_dropped", 32'(gnt_seen), 32'd0);
        step(0);
        check("timeout_one_cycle", 32'(tm_seen), 32'd0);
        check("timeout_next_owner", 32'(gnt_seen), 32'b1000);
        run_all(200);

        // Transmitter stalls 1000 cycles: byte held, no timeout, no handshake
        do_reset();
        push_byte(1, 8'h90, 1'b0);
        push_byte(1, 8'h91, 1'b1);
        push_byte(2, 8'h92, 1'b1);
        build_expected();
        n = 0;
        while (!txv_seen && n < 20) begin
            step(0);
            n++;
        end
        held = txd_seen;
        check("stall_data", 32'(held), 32'h90);
        bad_stable = 0;
        bad_tm     = 0;
        bad_rdy    = 0;
        repeat (1000) begin
            step(0);
            if (!txv_seen || txd_seen !== held) bad_stable++;
            if (tm_seen) bad_tm++;
            if (rdy_seen != '0) bad_rdy++;
        end
        check("stall_stable", 32'(bad_stable), 32'd0);
        check("stall_no_timeout", 32'(bad_tm), 32'd0);
        check("stall_no_ready", 32'(bad_rdy), 32'd0);
        run_all(200);

        // Reset while a byte sits in SEND
        do_reset();
        push_byte(2, 8'hE0, 1'b0);
        push_byte(2, 8'hE1, 1'b1);
        build_expected();
        n = 0;
        while (!txv_seen && n < 20) begin
            step(0);
            n++;
        end
        check("send_reached", 32'(txv_seen), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("midreset_txv", 32'(tx_data_valid), 32'd0);
        check("midreset_grant", 32'(grant), 32'd0);
        check("midreset_txd", 32'(tx_data), 32'd0);
        do_reset();
        push_byte(2, 8'hE2, 1'b1);
        push_byte(0, 8'hE3, 1'b1);
        build_expected();
        step(0);
        step(0);
        check("post_reset_first_grant", 32'(gnt_seen), 32'b0001);
        run_all(200);

        // Randomized message traffic against the model
        do_reset();
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < N; i++) begin
                int nmsg;
                nmsg = $urandom_range(0, 3);
                for (int m = 0; m < nmsg; m++) begin
                    int len;
                    len = $urandom_range(1, 4);
                    for (int b = 0; b < len; b++)
                        push_byte(i, 8'($urandom), (b == len - 1) ? 1'b1 : 1'b0);
                end
            end
            build_expected();
            run_all(3000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
